// File: rtl/vector_alu_sequencer.sv
// Issues the lanes of one vector operation to a single shared scalar ALU,
// one lane per cycle, and gathers the lane results into a result vector.
module vector_alu_sequencer #(
  parameter int LANES = 4,
  parameter int WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [2:0]             op,
  input  logic                   vcsub,
  input  logic [LANES*WIDTH-1:0] vec_a,
  input  logic [LANES*WIDTH-1:0] vec_b,
  input  logic                   abort,
  output logic                   busy,
  output logic                   done,
  output logic [LANES*WIDTH-1:0] result,
  output logic [2:0]             alu_op,
  output logic                   alu_vcsub,
  output logic [WIDTH-1:0]       alu_a,
  output logic [WIDTH-1:0]       alu_b,
  input  logic [WIDTH-1:0]       alu_out
);

  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

  state_t                 state, state_n;
  logic [LW-1:0]          lane;
  logic [2:0]             op_q;
  logic                   vcsub_q;
  logic [LANES*WIDTH-1:0] a_q, b_q;
  logic                   last_lane;

  assign last_lane = (lane == LW'(LANES - 1));

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = ISSUE;
      ISSUE:   if (abort) state_n = IDLE;
               else if (last_lane) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // An aborted ISSUE cycle does not write its lane, so unissued lanes stay 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      lane    <= '0;
      op_q    <= '0;
      vcsub_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      result  <= '0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: begin
          if (start) begin
            op_q    <= op;
            vcsub_q <= vcsub;
            a_q     <= vec_a;
            b_q     <= vec_b;
            result  <= '0;
            lane    <= '0;
          end
        end
        ISSUE: begin
          if (!abort) begin
            result[int'(lane)*WIDTH +: WIDTH] <= alu_out;
            if (!last_lane) lane <= lane + LW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // The ALU inputs are held at zero outside ISSUE so the idle ALU stays quiet.
  always_comb begin
    alu_op    = 3'b000;
    alu_vcsub = 1'b0;
    alu_a     = '0;
    alu_b     = '0;
    if (state == ISSUE) begin
      alu_op    = op_q;
      alu_vcsub = vcsub_q;
      alu_a     = a_q[int'(lane)*WIDTH +: WIDTH];
      alu_b     = b_q[int'(lane)*WIDTH +: WIDTH];
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_vector_alu_sequencer.sv
// Randomized self-checking bench for vector_alu_sequencer with a stand-in
// scalar ALU and a lane-by-lane reference model of the vector result.
module tb_vector_alu_sequencer;

  localparam int LANES = 4;
  localparam int W     = 32;
  localparam int V     = LANES * W;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [2:0]    op = '0;
  logic          vcsub = 1'b0;
  logic [V-1:0]  vec_a = '0, vec_b = '0;
  logic          abort = 1'b0;
  logic          busy, done;
  logic [V-1:0]  result;
  logic [2:0]    alu_op;
  logic          alu_vcsub;
  logic [W-1:0]  alu_a, alu_b, alu_out;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  vector_alu_sequencer #(.LANES(LANES), .WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .vcsub(vcsub),
    .vec_a(vec_a), .vec_b(vec_b), .abort(abort), .busy(busy), .done(done),
    .result(result), .alu_op(alu_op), .alu_vcsub(alu_vcsub),
    .alu_a(alu_a), .alu_b(alu_b), .alu_out(alu_out)
  );

  // Stand-in scalar ALU; opcode 101 uses an arbitrary fixed formula.
  function automatic logic [W-1:0] alu_fn(logic [2:0] o, logic vc, logic [W-1:0] a, logic [W-1:0] b);
    case (o)
      3'b010:  return a * b;
      3'b001:  return (vc && a < b) ? a : a - b;
      3'b111:  return a >> b[4:0];
      3'b101:  return ((a + b) >> 1) - 32'd2;
      default: return a ^ b;
    endcase
  endfunction

  assign alu_out = alu_fn(alu_op, alu_vcsub, alu_a, alu_b);

  // Expected vector: the first n lanes hold the ALU result, the rest are 0.
  function automatic logic [V-1:0] model(logic [2:0] o, logic vc, logic [V-1:0] a, logic [V-1:0] b, int n);
    logic [V-1:0] r;
    r = '0;
    for (int i = 0; i < n; i++) r[i*W +: W] = alu_fn(o, vc, a[i*W +: W], b[i*W +: W]);
    return r;
  endfunction

  function automatic logic [V-1:0] splat(logic [W-1:0] x);
    return {LANES{x}};
  endfunction

  function automatic logic [V-1:0] rand_vec();
    logic [V-1:0] r;
    for (int i = 0; i < LANES; i++) r[i*W +: W] = $urandom;
    return r;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    nvec++;
    if ({busy, done, alu_op, alu_vcsub} !== 6'b0 || result !== '0 || alu_a !== '0 || alu_b !== '0) begin
      nerr++;
      $display("[TB] FAIL reset_outputs: busy=%0b done=%0b result=%h alu_a=%h expected all 0", busy, done, result, alu_a);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // One operation from IDLE; optionally aborted at issue cycle abort_at,
  // disturbed by a start pulse mid-issue, or started with abort high.
  task automatic test_op(input string name, input logic [2:0] o, input logic vc,
                         input logic [V-1:0] a, input logic [V-1:0] b,
                         input int abort_at, input bit glitch, input bit abort_with_start,
                         output logic [V-1:0] got);
    logic [V-1:0] exp;
    exp = model(o, vc, a, b, (abort_at < 0) ? LANES : abort_at);
    start = 1'b1; op = o; vcsub = vc; vec_a = a; vec_b = b; abort = abort_with_start;
    @(negedge clk);
    start = 1'b0; abort = 1'b0; op = 3'($urandom); vcsub = ~vc;
    vec_a = rand_vec(); vec_b = rand_vec();
    for (int i = 0; i < LANES; i++) begin
      nvec++;
      if (busy !== 1'b1 || done !== 1'b0 || alu_op !== o || alu_vcsub !== vc ||
          alu_a !== a[i*W +: W] || alu_b !== b[i*W +: W]) begin
        nerr++;
        $display("[TB] FAIL %s issue%0d: busy=%0b done=%0b op=%b a=%h b=%h expected 1 0 %b %h %h",
                 name, i, busy, done, alu_op, alu_a, alu_b, o, a[i*W +: W], b[i*W +: W]);
      end
      start = glitch && (i == 1);
      abort = (i == abort_at);
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      if (i == abort_at) begin
        nvec++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== exp) begin
          nerr++;
          $display("[TB] FAIL %s abort: busy=%0b done=%0b result=%h expected 0 0 %h", name, busy, done, result, exp);
        end
        got = result;
        return;
      end
    end
    nvec++;
    if (done !== 1'b1 || busy !== 1'b1 || alu_op !== 3'b000 || alu_a !== '0 || result !== exp) begin
      nerr++;
      $display("[TB] FAIL %s done_cycle: done=%0b busy=%0b alu_op=%b result=%h expected 1 1 000 %h",
               name, done, busy, alu_op, result, exp);
    end
    got = result;
    @(negedge clk);
    nvec++;
    if (done !== 1'b0 || busy !== 1'b0 || result !== exp) begin
      nerr++;
      $display("[TB] FAIL %s idle_after: done=%0b busy=%0b result=%h expected 0 0 %h", name, done, busy, result, exp);
    end
  endtask

  task automatic test_mul();
    logic [V-1:0] got;
    test_op("mul", 3'b010, 1'b0, splat(32'd1250), splat(32'd342), -1, 1'b0, 1'b0, got);
    nvec++;
    if (got !== splat(32'd427500)) begin
      nerr++;
      $display("[TB] FAIL mul_value: got %h expected %h", got, splat(32'd427500));
    end
  endtask

  task automatic test_condsub();
    logic [V-1:0] got;
    logic [V-1:0] a, b, e;
    a = {32'd0, 32'd342, 32'd100, 32'd1250};
    b = {32'd0, 32'd342, 32'd342, 32'd342};
    e = {32'd0, 32'd0, 32'd100, 32'd908};
    test_op("condsub", 3'b001, 1'b1, a, b, -1, 1'b0, 1'b0, got);
    nvec++;
    if (got !== e) begin
      nerr++;
      $display("[TB] FAIL condsub_value: got %h expected %h", got, e);
    end
    test_op("sub", 3'b001, 1'b0, a, b, -1, 1'b0, 1'b0, got);
    nvec++;
    if (got[W-1:0] !== 32'd908) begin
      nerr++;
      $display("[TB] FAIL sub_lane0: got %0d expected 908", got[W-1:0]);
    end
  endtask

  task automatic test_back_to_back();
    logic [V-1:0] got;
    test_op("bilinear", 3'b101, 1'b0, {96'd0, 32'd10}, {96'd0, 32'd20}, -1, 1'b0, 1'b0, got);
    nvec++;
    if (got[W-1:0] !== 32'd13) begin
      nerr++;
      $display("[TB] FAIL bilinear_lane0: got %0d expected 13", got[W-1:0]);
    end
    test_op("shift", 3'b111, 1'b0, {96'd0, 32'h38000000}, {96'd0, 32'd23}, -1, 1'b0, 1'b0, got);
    nvec++;
    if (got[W-1:0] !== 32'h00000070) begin
      nerr++;
      $display("[TB] FAIL shift_lane0: got %h expected 00000070", got[W-1:0]);
    end
  endtask

  task automatic test_start_held();
    logic [V-1:0] a, b, exp;
    bit exp_done;
    int ndone;
    a = rand_vec(); b = rand_vec();
    exp = model(3'b010, 1'b0, a, b, LANES);
    ndone = 0;
    start = 1'b1; op = 3'b010; vcsub = 1'b0; vec_a = a; vec_b = b;
    for (int c = 1; c <= 3 * (LANES + 2); c++) begin
      @(negedge clk);
      exp_done = (c % (LANES + 2)) == LANES + 1;
      if (done === 1'b1) ndone++;
      nvec++;
      if (done !== exp_done || busy !== ((c % (LANES + 2)) != 0) || (exp_done && result !== exp)) begin
        nerr++;
        $display("[TB] FAIL held_start c%0d: done=%0b busy=%0b result=%h expected done=%0b result=%h",
                 c, done, busy, result, exp_done, exp);
      end
    end
    start = 1'b0;
    nvec++;
    if (ndone != 3) begin
      nerr++;
      $display("[TB] FAIL held_start_count: got %0d done pulses expected 3", ndone);
    end
    @(negedge clk);
  endtask

  task automatic test_protocol();
    logic [V-1:0] got;
    test_op("glitch_start", 3'b010, 1'b0, rand_vec(), rand_vec(), -1, 1'b1, 1'b0, got);
    test_op("abort", 3'b001, 1'b1, rand_vec(), rand_vec(), 2, 1'b0, 1'b0, got);
    test_op("abort_with_start", 3'b111, 1'b0, rand_vec(), rand_vec(), -1, 1'b0, 1'b1, got);
  endtask

  task automatic test_reset_midop();
    logic [V-1:0] got;
    start = 1'b1; op = 3'b010; vcsub = 1'b0; vec_a = rand_vec(); vec_b = rand_vec();
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    nvec++;
    if ({busy, done, alu_op, alu_vcsub} !== 6'b0 || result !== '0 || alu_a !== '0 || alu_b !== '0) begin
      nerr++;
      $display("[TB] FAIL reset_midop: busy=%0b done=%0b result=%h alu_op=%b expected all 0", busy, done, result, alu_op);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_op("after_reset", 3'b010, 1'b0, rand_vec(), rand_vec(), -1, 1'b0, 1'b0, got);
  endtask

  task automatic test_random();
    logic [V-1:0] got;
    logic [2:0] ops [6] = '{3'b010, 3'b001, 3'b111, 3'b101, 3'b000, 3'b110};
    for (int k = 0; k < 8; k++) begin
      test_op("random", ops[$urandom_range(5)], 1'($urandom), rand_vec(), rand_vec(),
              ($urandom_range(3) == 0) ? int'($urandom_range(LANES - 1)) : -1,
              1'($urandom), 1'b0, got);
      if ($urandom_range(1) == 1) @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_condsub();
    test_back_to_back();
    test_start_held();
    test_protocol();
    test_reset_midop();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
